muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
Iterative unsigned multiply/divide sequencer that time-shares the existing combinational ALU instead of adding a dedicated multiplier or divider. It accepts one request through a valid/ready handshake, then drives the ALU's A/B/op inputs for WIDTH iterations: shift-add for multiply, restoring subtract for divide. It returns the result through a valid/ready response port and sits beside the ALU in the execute stage.

Parameters:
WIDTH, `WIDTH (32), operand/result width; must match the ALU instance.
CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, never overridden.

Ports:
clk  in  1  clock; all state updates on posedge.
rst_n  in  1  synchronous reset, active-low.
req_valid  in  1  request present.
req_ready  out  1  high only in IDLE.
req_op  in  2  00 MUL (low word), 01 MULHU (high word), 10 DIVU, 11 REMU.
req_a  in  WIDTH  multiplicand / dividend.
req_b  in  WIDTH  multiplier / divisor.
resp_valid  out  1  result available.
resp_ready  in  1  consumer accepts result.
resp_data  out  WIDTH  result.
resp_dbz  out  1  divide-by-zero flag; valid with resp_valid.
alu_a  out  WIDTH  to ALU A.
alu_b  out  WIDTH  to ALU B.
alu_op  out  `ALU_OP_LEN  to ALU alu_op.
alu_out  in  WIDTH  from ALU out (combinational, same cycle).

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, counter=0. req_ready, resp_valid and resp_dbz are 0, and resp_data is 0. Reset mid-operation abandons the operation with no response. req_ready reads 1 from the first cycle after reset.
- States:
  - IDLE: req_ready=1. On req_valid, latch op/a/b and clear counter. If op is DIV/REM and b==0, go to DONE; otherwise go to BUSY.
  - BUSY: one iteration per cycle. After exactly WIDTH iterations, go to DONE.
  - DONE: resp_valid=1. Go to IDLE on resp_ready. resp_data and resp_dbz are held stable while resp_ready=0.
- No request is accepted in BUSY or DONE. A response handshake and a new request are never accepted in the same cycle.
- Latency: accept at cycle 0; resp_valid is high from cycle WIDTH+1. For divide-by-zero, resp_valid is high from cycle 1.
- ALU drive when not iterating (IDLE, DONE): alu_op=`ALU_COPY_A, alu_a=0, alu_b=0.
- Multiply registers: hi=0, lo=req_b, mc=req_a at accept. Each iteration:
  - If lo[0]=1: alu_op=`ALU_ADD, alu_a=hi, alu_b=mc, s=alu_out, carry=(alu_out < hi), unsigned compare done locally.
  - If lo[0]=0: alu_op=`ALU_COPY_A, alu_a=hi, s=hi, carry=0.
  - Update {hi,lo} <= {carry,s,lo} >> 1.
  - Result: MUL returns lo, MULHU returns hi.
- Divide registers: rem=0, q=req_a, dv=req_b at accept. Each iteration:
  - sh={rem[W-2:0],q[W-1]}, alu_op=`ALU_SUB, alu_a=sh, alu_b=dv.
  - ge = rem[W-1] | !(sh < dv).
  - If ge: rem<=alu_out, qbit=1. Otherwise: rem<=sh, qbit=0.
  - q<={q[W-2:0],qbit}.
  - Result: DIVU returns q, REMU returns rem.
- Divide-by-zero: DIVU returns all-ones, REMU returns req_a, resp_dbz=1. resp_dbz=0 for all other responses.
- All arithmetic is modulo 2^WIDTH; carry and borrow are derived only by the local unsigned compares above. The ALU overflow output is unused.
- The counter increments only in BUSY. BUSY→DONE occurs when the counter equals WIDTH-1 at the update edge.

Test Plan:
1. MUL 7×6, resp_ready=1 → req_ready drops at cycle 1; resp_valid at cycle 33 with resp_data=0x0000002A, dbz=0; req_ready=1 at cycle 34.
2. MUL and MULHU on 0xFFFFFFFF×0xFFFFFFFF → 0x00000001 and 0xFFFFFFFE respectively. MULHU 0x80000000×2 → 0x00000001.
3. DIVU 100/7 → 0x0000000E; REMU 100/7 → 0x00000002. DIVU 0x80000000/1 → 0x80000000 (exercises rem[W-1] path). DIVU 3/0xFFFFFFFF → 0, REMU → 3.
4. DIVU 5/0 → resp_valid at cycle 1, resp_data=0xFFFFFFFF, dbz=1. REMU 5/0 → 0x00000005, dbz=1.
5. Backpressure: hold resp_ready=0 for 5 cycles in DONE, with req_valid=1 throughout.
   - resp_valid stays 1 and resp_data stays stable; req_ready stays 0.
   - After the handshake, the next request is accepted one cycle later.
6. Reset mid-operation: assert rst_n=0 at iteration 10 of a DIVU.
   - Next cycle: resp_valid=0, alu_op=`ALU_COPY_A, req_ready=1 after release.
   - A following MUL 3×5 returns 15 with normal latency.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply/divide sequencer that borrows the execute-stage ALU.
// Shift-add multiply and restoring divide, one bit per cycle, valid/ready on both sides.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef ALU_OP_LEN
`define ALU_OP_LEN 4
`endif
`ifndef ALU_COPY_A
`define ALU_COPY_A 4'd0
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'd1
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'd2
`endif

module muldiv_seq #(
  parameter int WIDTH = `WIDTH,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [WIDTH-1:0]       req_a,
  input  logic [WIDTH-1:0]       req_b,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [WIDTH-1:0]       resp_data,
  output logic                   resp_dbz,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [`ALU_OP_LEN-1:0] alu_op,
  input  logic [WIDTH-1:0]       alu_out
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;

  state_t           state_reg, state_next;
  logic [1:0]       op_reg, op_next;
  // acc: hi (multiply) / rem (divide); shf: lo / q; opd: mc / dv
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0] shf_reg, shf_next;
  logic [WIDTH-1:0] opd_reg, opd_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             dbz_reg, dbz_next;

  logic [WIDTH-1:0] sum;
  logic             carry;
  logic [WIDTH-1:0] sh;
  logic             ge;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      op_reg    <= '0;
      acc_reg   <= '0;
      shf_reg   <= '0;
      opd_reg   <= '0;
      cnt_reg   <= '0;
      dbz_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      acc_reg   <= acc_next;
      shf_reg   <= shf_next;
      opd_reg   <= opd_next;
      cnt_reg   <= cnt_next;
      dbz_reg   <= dbz_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    acc_next   = acc_reg;
    shf_next   = shf_reg;
    opd_next   = opd_reg;
    cnt_next   = cnt_reg;
    dbz_next   = dbz_reg;
    alu_op     = `ALU_COPY_A;
    alu_a      = '0;
    alu_b      = '0;
    sum        = '0;
    carry      = 1'b0;
    sh         = '0;
    ge         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          op_next  = req_op;
          acc_next = '0;
          // Divide shifts the dividend out of shf; multiply shifts the multiplier.
          shf_next = req_op[1] ? req_a : req_b;
          opd_next = req_op[1] ? req_b : req_a;
          cnt_next = '0;
          dbz_next = req_op[1] && (req_b == '0);
          state_next = (req_op[1] && (req_b == '0)) ? DONE : BUSY;
        end
      end

      BUSY: begin
        cnt_next = cnt_reg + 1'b1;
        if (!op_reg[1]) begin
          alu_a = acc_reg;
          if (shf_reg[0]) begin
            alu_op = `ALU_ADD;
            alu_b  = opd_reg;
            sum    = alu_out;
            carry  = (alu_out < acc_reg);
          end else begin
            sum    = acc_reg;
            carry  = 1'b0;
          end
          acc_next = {carry, sum[WIDTH-1:1]};
          shf_next = {sum[0], shf_reg[WIDTH-1:1]};
        end else begin
          sh     = {acc_reg[WIDTH-2:0], shf_reg[WIDTH-1]};
          alu_op = `ALU_SUB;
          alu_a  = sh;
          alu_b  = opd_reg;
          ge     = acc_reg[WIDTH-1] | !(sh < opd_reg);
          acc_next = ge ? alu_out : sh;
          shf_next = {shf_reg[WIDTH-2:0], ge};
        end
        if (cnt_reg == CNT_W'(WIDTH - 1)) begin
          state_next = DONE;
        end
      end

      DONE: begin
        if (resp_ready) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    resp_data = '0;
    if (state_reg == DONE) begin
      case (op_reg)
        OP_MUL:   resp_data = shf_reg;
        OP_MULHU: resp_data = acc_reg;
        OP_DIVU:  resp_data = dbz_reg ? '1 : shf_reg;
        default:  resp_data = dbz_reg ? shf_reg : acc_reg;
      endcase
    end
  end

  // Gated with rst_n so nothing is accepted while reset is held.
  assign req_ready  = (state_reg == IDLE) && rst_n;
  assign resp_valid = (state_reg == DONE);
  assign resp_dbz   = (state_reg == DONE) && dbz_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a behavioural ALU beside it.
`ifndef ALU_OP_LEN
`define ALU_OP_LEN 4
`endif
`ifndef ALU_COPY_A
`define ALU_COPY_A 4'd0
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'd1
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'd2
`endif

module tb_muldiv_seq;
  localparam int W = 32;
  localparam int NV = 17;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   req_valid = 1'b0;
  logic                   req_ready;
  logic [1:0]             req_op = 2'b00;
  logic [W-1:0]           req_a = '0;
  logic [W-1:0]           req_b = '0;
  logic                   resp_valid;
  logic                   resp_ready = 1'b1;
  logic [W-1:0]           resp_data;
  logic                   resp_dbz;
  logic [W-1:0]           alu_a;
  logic [W-1:0]           alu_b;
  logic [`ALU_OP_LEN-1:0] alu_op;
  logic [W-1:0]           alu_out;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_dbz(resp_dbz),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_out = alu_a;
    case (alu_op)
      `ALU_ADD: alu_out = alu_a + alu_b;
      `ALU_SUB: alu_out = alu_a - alu_b;
      default:  alu_out = alu_a;
    endcase
  end

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    logic         dbz;
    int           lat;
  } vec_t;

  vec_t vecs[NV];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    @(negedge clk);
    req_valid = 1'b1; req_op = v.op; req_a = v.a; req_b = v.b;
    check("req_ready_before_accept", W'(req_ready), W'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp(lat);
    $display("txn op=%0d a=%h b=%h data=%h dbz=%0b lat=%0d", v.op, v.a, v.b, resp_data, resp_dbz, lat);
    check("latency", W'(lat), W'(v.lat));
    check("resp_data", resp_data, v.exp);
    check("resp_dbz", W'(resp_dbz), W'(v.dbz));
    @(posedge clk); #1;
    check("resp_valid_after_hs", W'(resp_valid), W'(0));
    check("req_ready_after_hs", W'(req_ready), W'(1));
    check("idle_alu_op", W'(alu_op), W'(`ALU_COPY_A));
    check("idle_alu_a", alu_a, W'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    vecs[0]  = '{2'b00, 32'd7,         32'd6,         32'h0000002A, 1'b0, 33};
    vecs[1]  = '{2'b00, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001, 1'b0, 33};
    vecs[2]  = '{2'b01, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE, 1'b0, 33};
    vecs[3]  = '{2'b01, 32'h80000000,  32'd2,         32'h00000001, 1'b0, 33};
    vecs[4]  = '{2'b10, 32'd100,       32'd7,         32'h0000000E, 1'b0, 33};
    vecs[5]  = '{2'b11, 32'd100,       32'd7,         32'h00000002, 1'b0, 33};
    vecs[6]  = '{2'b10, 32'h80000000,  32'd1,         32'h80000000, 1'b0, 33};
    vecs[7]  = '{2'b10, 32'd3,         32'hFFFFFFFF,  32'h00000000, 1'b0, 33};
    vecs[8]  = '{2'b11, 32'd3,         32'hFFFFFFFF,  32'h00000003, 1'b0, 33};
    vecs[9]  = '{2'b10, 32'd5,         32'd0,         32'hFFFFFFFF, 1'b1, 1};
    vecs[10] = '{2'b11, 32'd5,         32'd0,         32'h00000005, 1'b1, 1};
    vecs[11] = '{2'b00, 32'h12345678,  32'h00000010,  32'h23456780, 1'b0, 33};
    vecs[12] = '{2'b01, 32'h12345678,  32'h00000010,  32'h00000001, 1'b0, 33};
    vecs[13] = '{2'b10, 32'hFFFFFFFF,  32'h00000010,  32'h0FFFFFFF, 1'b0, 33};
    vecs[14] = '{2'b11, 32'hFFFFFFFF,  32'h00000010,  32'h0000000F, 1'b0, 33};
    vecs[15] = '{2'b00, 32'hFFFFFFFF,  32'd2,         32'hFFFFFFFE, 1'b0, 33};
    vecs[16] = '{2'b01, 32'hFFFFFFFF,  32'd2,         32'h00000001, 1'b0, 33};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", W'(req_ready), W'(0));
    check("rst_resp_valid", W'(resp_valid), W'(0));
    check("rst_resp_dbz", W'(resp_dbz), W'(0));
    check("rst_resp_data", resp_data, W'(0));
    check("rst_alu_op", W'(alu_op), W'(`ALU_COPY_A));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_req_ready", W'(req_ready), W'(1));

    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i]);
    end

    // Backpressure in DONE with a request waiting
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_op = 2'b00; req_a = 32'd7; req_b = 32'd6;
    @(posedge clk); #1;
    req_op = 2'b10; req_a = 32'd100; req_b = 32'd7;
    check("bp_busy_req_ready", W'(req_ready), W'(0));
    wait_resp(lat);
    check("bp_latency", W'(lat), W'(33));
    for (int k = 0; k < 5; k++) begin
      check("bp_resp_valid", W'(resp_valid), W'(1));
      check("bp_resp_data", resp_data, 32'h0000002A);
      check("bp_resp_dbz", W'(resp_dbz), W'(0));
      check("bp_req_ready", W'(req_ready), W'(0));
      @(posedge clk); #1;
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    $display("txn op=0 a=00000007 b=00000006 data=0000002a dbz=0 backpressured");
    check("bp_hs_resp_valid", W'(resp_valid), W'(0));
    check("bp_hs_req_ready", W'(req_ready), W'(1));
    @(posedge clk); #1;
    check("bp_next_accepted", W'(req_ready), W'(0));
    req_valid = 1'b0;
    wait_resp(lat);
    $display("txn op=2 a=00000064 b=00000007 data=%h dbz=%0b lat=%0d", resp_data, resp_dbz, lat);
    check("bp_next_latency", W'(lat), W'(33));
    check("bp_next_data", resp_data, 32'h0000000E);
    @(posedge clk); #1;

    // Reset in the middle of a divide
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b10; req_a = 32'hFFFF0000; req_b = 32'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("mid_busy_alu_op", W'(alu_op), W'(`ALU_SUB));
    rst_n = 1'b0;
    @(posedge clk); #1;
    $display("txn op=2 a=ffff0000 b=00000003 abandoned by reset");
    check("mid_rst_resp_valid", W'(resp_valid), W'(0));
    check("mid_rst_alu_op", W'(alu_op), W'(`ALU_COPY_A));
    check("mid_rst_alu_a", alu_a, W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rst_req_ready", W'(req_ready), W'(1));
    run_vec('{2'b00, 32'd3, 32'd5, 32'h0000000F, 1'b0, 33});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
